sd_inv: RTL
===========

Name: sd_inv

Overview:
- Bit-serial inverse of the 4-bit add/sub unit.
- Input: a forward result `r`, the known first operand `a`, and the forward op flag `check`. Output: the missing second operand `b`.
- Used on the consumer/check side of the add/sub datapath to undo an operation or to cross-check operands.
- Processes one bit per clock. Valid/ready handshake on both input and output.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- r  input  WIDTH  forward result (sum or difference)
- a  input  WIDTH  known first operand
- check  input  1  forward op: 0 = r was a+b, 1 = r was a-b
- out_valid  output  1  b is valid
- out_ready  input  1  downstream accepts b
- b  output  WIDTH  recovered second operand

Behaviour:
- Arithmetic, all modulo 2^WIDTH:
  - check=0: b = r - a.
  - check=1: b = a - r.
- Bit-serial subtract x - y, with x,y = (r,a) for check=0 and (a,r) for check=1:
  - computed as x + ~y + 1;
  - carry register initialised to 1 at accept;
  - LSB first.
- FSM states:
  - IDLE: in_ready=1. On in_valid=1, latch x, y and check, clear bit index, set carry=1, go to RUN.
  - RUN: one bit per edge. After the WIDTH-th bit, go to DONE. in_ready=0.
  - DONE: out_valid=1 and b is stable. On out_ready=1, go to IDLE on that edge. in_ready=0.
- Latency: accept edge E0; bits computed on edges E1..EWIDTH; out_valid high after edge EWIDTH. For WIDTH=4, out_valid rises 4 edges after accept.
- Throughput: one result per WIDTH+2 cycles minimum (no accept in the same cycle as output handoff).
- in_ready is combinational from state only (IDLE), never from in_valid.
- Inputs are sampled only on the accept edge; r/a/check changes during RUN/DONE have no effect.
- out_valid held with b constant until out_ready=1. out_ready while not in DONE is ignored.
- Reset (asynchronous, any state including mid-RUN):
  - state=IDLE, in_ready=1 after reset release;
  - out_valid=0, b=0, carry=1, bit index=0;
  - any in-flight request is discarded.
- Boundaries:
  - r=a gives b=0.
  - Full wrap behaves modularly: check=0, r=0, a=1 gives b=2^WIDTH-1.
  - The bit index wraps only via the transition to DONE; no extra cycles are added.

Optional Feature:
- Macro: SD_INV_WRAP_FLAG_EN.
- When defined:
  - adds output port `wrap` (1 bit, valid with out_valid, reset 0);
  - `wrap` = NOT final carry of the serial subtraction;
  - check=0: 1 means the forward a+b overflowed;
  - check=1: 1 means the forward a-b underflowed (b>a).
- When undefined: no `wrap` port and no extra logic; all other behaviour is identical.

Test Plan:
- Reset mid-operation: accept a request, assert rst_n=0 during RUN, release -> in_ready=1, out_valid=0, b=0; the next request computes correctly.
- check=0, r=9, a=5 -> b=4 exactly 4 edges after accept (wrap=0 if enabled).
- check=0, r=2, a=7 -> b=11 (wrap=1); check=1, r=3, a=10 -> b=7 (wrap=0).
- check=1, r=13, a=4 -> b=7 (wrap=1, forward 4-7 underflowed); r=a=6 with either check -> b=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, and toggle r/a/in_valid meanwhile -> b stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
- Random: 200 back-to-back requests, with out_ready high or randomly held low, compared against the modular reference model -> all match; no lost or duplicated results.

Source files
------------

// File: rtl/sd_inv.sv
// Bit-serial inverse of the add/sub unit: recovers b from r and a, LSB first, one bit per clock.
// Optional `wrap` output (NOT final carry) is enabled by defining SD_INV_WRAP_FLAG_EN.
module sd_inv #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] a,
  input  logic             check,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SD_INV_WRAP_FLAG_EN
  output logic             wrap,
`endif
  output logic [WIDTH-1:0] b
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             w_accept;
  logic             w_last;
  logic             w_xb;
  logic             w_yb;
  logic             w_sum;
  logic             w_cout;

  // x - y computed as x + ~y + 1; the +1 comes from the carry preset at accept.
  assign w_xb   = r_x[r_idx];
  assign w_yb   = ~r_y[r_idx];
  assign w_sum  = w_xb ^ w_yb ^ r_carry;
  assign w_cout = (w_xb & w_yb) | (w_xb & r_carry) | (w_yb & r_carry);
  assign w_last = (r_idx == IW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are swapped at accept so the serial loop is always x - y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b1;
    end else if (w_accept) begin
      r_x     <= check ? a : r;
      r_y     <= check ? r : a;
      r_idx   <= '0;
      r_carry <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_b[r_idx] <= w_sum;
      r_carry    <= w_cout;
      r_idx      <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  assign b = r_b;

`ifdef SD_INV_WRAP_FLAG_EN
  assign wrap = ~r_carry;
`endif

endmodule
